// File: rtl/uart_frame_parser_if.sv
// ----------------------------------------------------------------------------
// uart_frame_parser_if
// Groups the frame parser's RX-FIFO side and payload-stream side signals.
//   RX FIFO side : i_rx_empty, i_rx_data, i_err (to parser), o_rd_uart (pop)
//   Stream side  : o_data, o_valid, o_last (to sink), i_ready (from sink)
//   Status       : o_frame_ok, o_frame_err, o_err_code
// slave  modport : the parser itself
// master modport : whatever surrounds the parser (FIFO + sink)
// ----------------------------------------------------------------------------
interface uart_frame_parser_if;
  logic       i_rx_empty;
  logic [7:0] i_rx_data;
  logic [2:0] i_err;
  logic       o_rd_uart;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_last;
  logic       o_frame_ok;
  logic       o_frame_err;
  logic [1:0] o_err_code;

  modport slave (
    input  i_rx_empty, i_rx_data, i_err, i_ready,
    output o_rd_uart, o_data, o_valid, o_last, o_frame_ok, o_frame_err, o_err_code
  );

  modport master (
    output i_rx_empty, i_rx_data, i_err, i_ready,
    input  o_rd_uart, o_data, o_valid, o_last, o_frame_ok, o_frame_err, o_err_code
  );
endinterface

// File: rtl/uart_frame_parser.sv
// ----------------------------------------------------------------------------
// uart_frame_parser
// Pops bytes from a UART RX FIFO, hunts for SOF, parses a frame
//   SOF, LEN (1..MAX_LEN), LEN payload bytes, CHK
// into an internal buffer and, once (LEN + payload + CHK) mod 256 == 0,
// releases the payload on a valid/ready byte stream. Line errors, bad
// lengths, bad checksums and mid-frame stalls abort the frame.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   bus      uart_frame_parser_if.slave (FIFO pop side, stream side, status)
// ----------------------------------------------------------------------------
module uart_frame_parser #(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SOF            = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  uart_frame_parser_if.slave bus
);

  localparam int IDX_W  = $clog2(MAX_LEN + 1);
  localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  // A disabled timeout still needs a 1-bit counter to keep the logic legal.
  localparam int IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST =
    (TIMEOUT_CYCLES > 0) ? IDLE_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_SEND    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [IDX_W-1:0]  r_len;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_next;
  logic [7:0]        r_acc;
  logic [7:0]        w_chk_sum;
  logic [IDLE_W-1:0] r_idle;
  logic [7:0]        r_buf [MAX_LEN];
  logic [7:0]        r_data;
  logic              r_valid;
  logic              r_last;
  logic              r_frame_ok;
  logic              r_frame_err;
  logic [1:0]        r_err_code;

  logic       w_pop;
  logic       w_in_frame;
  logic       w_line_err;
  logic       w_len_bad;
  logic       w_idle_hit;
  logic       w_payload_last;
  logic       w_send_fire;
  logic       w_abort;
  logic [1:0] w_abort_code;
  logic       w_frame_ok;

  // Pop is combinational so the head byte is consumed in the same cycle;
  // reset forces it low even though the state register already reads HUNT.
  assign bus.o_rd_uart = i_rst_n & ~bus.i_rx_empty & (r_state != ST_SEND);
  assign w_pop         = bus.o_rd_uart;

  assign w_in_frame     = (r_state == ST_LEN) | (r_state == ST_PAYLOAD) | (r_state == ST_CHK);
  assign w_line_err     = w_pop & w_in_frame & (bus.i_err != 3'b000);
  assign w_len_bad      = (bus.i_rx_data == 8'd0) | (bus.i_rx_data > 8'(MAX_LEN));
  assign w_idle_hit     = (TIMEOUT_CYCLES != 0) & ~w_pop & (r_idle == IDLE_LAST);
  assign w_payload_last = (r_idx == (r_len - IDX_W'(1)));
  assign w_chk_sum      = r_acc + bus.i_rx_data;
  assign w_send_fire    = r_valid & bus.i_ready;
  assign w_idx_next     = r_idx + IDX_W'(1);

  assign bus.o_data      = r_data;
  assign bus.o_valid     = r_valid;
  assign bus.o_last      = r_last;
  assign bus.o_frame_ok  = r_frame_ok;
  assign bus.o_frame_err = r_frame_err;
  assign bus.o_err_code  = r_err_code;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode with abort/accept strobes; a line error outranks the
  // length and checksum checks on the same byte.
  always_comb begin
    w_next_state = r_state;
    w_abort      = 1'b0;
    w_abort_code = 2'b00;
    w_frame_ok   = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (w_pop && (bus.i_rx_data == SOF)) begin
          w_next_state = ST_LEN;
        end else begin
          w_next_state = ST_HUNT;
        end
      end
      ST_LEN: begin
        if (w_line_err) begin
          w_abort = 1'b1; w_abort_code = 2'b00; w_next_state = ST_HUNT;
        end else if (w_pop && w_len_bad) begin
          w_abort = 1'b1; w_abort_code = 2'b01; w_next_state = ST_HUNT;
        end else if (w_pop) begin
          w_next_state = ST_PAYLOAD;
        end else if (w_idle_hit) begin
          w_abort = 1'b1; w_abort_code = 2'b11; w_next_state = ST_HUNT;
        end else begin
          w_next_state = ST_LEN;
        end
      end
      ST_PAYLOAD: begin
        if (w_line_err) begin
          w_abort = 1'b1; w_abort_code = 2'b00; w_next_state = ST_HUNT;
        end else if (w_pop && w_payload_last) begin
          w_next_state = ST_CHK;
        end else if (w_pop) begin
          w_next_state = ST_PAYLOAD;
        end else if (w_idle_hit) begin
          w_abort = 1'b1; w_abort_code = 2'b11; w_next_state = ST_HUNT;
        end else begin
          w_next_state = ST_PAYLOAD;
        end
      end
      ST_CHK: begin
        if (w_line_err) begin
          w_abort = 1'b1; w_abort_code = 2'b00; w_next_state = ST_HUNT;
        end else if (w_pop && (w_chk_sum != 8'h00)) begin
          w_abort = 1'b1; w_abort_code = 2'b10; w_next_state = ST_HUNT;
        end else if (w_pop) begin
          w_frame_ok = 1'b1; w_next_state = ST_SEND;
        end else if (w_idle_hit) begin
          w_abort = 1'b1; w_abort_code = 2'b11; w_next_state = ST_HUNT;
        end else begin
          w_next_state = ST_CHK;
        end
      end
      ST_SEND: begin
        if (w_send_fire && r_last) begin
          w_next_state = ST_HUNT;
        end else begin
          w_next_state = ST_SEND;
        end
      end
      default: begin
        w_next_state = ST_HUNT;
      end
    endcase
  end

  // Length, index and checksum accumulator; r_idx is the write index while
  // parsing and the read index while sending.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len <= '0;
      r_idx <= '0;
      r_acc <= 8'h00;
    end else begin
      case (r_state)
        ST_HUNT: begin
          r_idx <= '0;
          if (w_pop && (bus.i_rx_data == SOF)) begin
            r_acc <= 8'h00;
          end else begin
            r_acc <= r_acc;
          end
        end
        ST_LEN: begin
          if (w_pop && !w_line_err && !w_len_bad) begin
            r_len <= IDX_W'(bus.i_rx_data);
            r_acc <= bus.i_rx_data;
            r_idx <= '0;
          end else begin
            r_len <= r_len;
          end
        end
        ST_PAYLOAD: begin
          if (w_pop) begin
            r_acc <= w_chk_sum;
            r_idx <= w_idx_next;
          end else begin
            r_acc <= r_acc;
          end
        end
        ST_CHK: begin
          r_idx <= '0;
        end
        ST_SEND: begin
          if (w_send_fire) begin
            r_idx <= w_idx_next;
          end else begin
            r_idx <= r_idx;
          end
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

  // Payload buffer write; storage needs no reset since it is only read after
  // being filled for the current frame.
  always_ff @(posedge i_clk) begin
    if ((r_state == ST_PAYLOAD) && w_pop) begin
      r_buf[r_idx[BUF_AW-1:0]] <= bus.i_rx_data;
    end
  end

  // Idle counter: counts pop-free cycles inside a frame, clears on any pop
  // and on every state change.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idle <= '0;
    end else if (w_in_frame && !w_pop && (w_next_state == r_state)) begin
      r_idle <= r_idle + IDLE_W'(1);
    end else begin
      r_idle <= '0;
    end
  end

  // Registered stream outputs and status pulses; o_data/o_last only move on
  // frame acceptance or a handshake, so they hold under backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      r_frame_ok  <= w_frame_ok;
      r_frame_err <= w_abort;
      r_err_code  <= w_abort ? w_abort_code : r_err_code;
      if (w_frame_ok) begin
        r_valid <= 1'b1;
        r_data  <= r_buf[BUF_AW'(0)];
        r_last  <= (r_len == IDX_W'(1));
      end else if (w_send_fire && r_last) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else if (w_send_fire) begin
        r_data  <= r_buf[w_idx_next[BUF_AW-1:0]];
        r_last  <= (w_idx_next == (r_len - IDX_W'(1)));
      end else begin
        r_valid <= r_valid;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// ----------------------------------------------------------------------------
// tb_uart_frame_parser
// Randomised and directed stimulus for uart_frame_parser. A FIFO model feeds
// byte streams; a frame-level reference parser predicts released payloads,
// frame_ok count and abort codes; observed traffic is compared against it.
// ----------------------------------------------------------------------------
module tb_uart_frame_parser;
  localparam int         MAX_LEN = 16;
  localparam logic [7:0] SOF     = 8'hA5;
  localparam int         TMO     = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_frame_parser_if u_if ();
  uart_frame_parser_if u_if_nt ();

  uart_frame_parser #(.MAX_LEN(MAX_LEN), .SOF(SOF), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(u_if.slave));

  uart_frame_parser #(.MAX_LEN(MAX_LEN), .SOF(SOF), .TIMEOUT_CYCLES(0)) dut_nt (
    .i_clk(clk), .i_rst_n(rst_n), .bus(u_if_nt.slave));

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] s_data[$];
  bit         s_err[$];
  int         ptr;
  logic [7:0] exp_bytes[$];
  bit         exp_last[$];
  int         exp_codes[$];
  int         exp_ok;
  logic [7:0] obs_bytes[$];
  bit         obs_last[$];
  int         obs_codes[$];
  int         obs_ok;
  int         pops, last_pop_cyc, err_cyc;
  bit         rand_stall;
  int         ready_mode;
  int         nt_err = 0;
  int         nt_ok  = 0;
  logic [7:0] nt_bytes [7] = '{8'hA5, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h52};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic new_scenario();
    s_data.delete(); s_err.delete(); ptr = 0;
    exp_bytes.delete(); exp_last.delete(); exp_codes.delete(); exp_ok = 0;
    obs_bytes.delete(); obs_last.delete(); obs_codes.delete(); obs_ok = 0;
    pops = 0; last_pop_cyc = -1; err_cyc = -1;
  endtask

  task automatic push(input logic [7:0] b, input bit e = 1'b0);
    s_data.push_back(b);
    s_err.push_back(e);
  endtask

  // err_at flags a line error on byte LEN(0), payload(1..len) or CHK(len+1).
  task automatic push_frame(input logic [7:0] pl[$], input bit bad_chk, input int err_at);
    int sum;
    int base;
    logic [7:0] chk;
    sum = pl.size();
    foreach (pl[k]) sum += pl[k];
    chk = 8'((256 - (sum % 256)) % 256);
    if (bad_chk) chk = chk ^ 8'($urandom_range(1, 255));
    base = s_data.size();
    push(SOF);
    push(8'(pl.size()));
    foreach (pl[k]) push(pl[k]);
    push(chk);
    if (err_at >= 0) s_err[base + 1 + err_at] = 1'b1;
  endtask

  // Reference: parse one frame whose LEN byte is at index i.
  // Returns -1 when accepted, else the abort code; nxt = first unconsumed byte.
  function automatic int parse_frame(input int i, output int nxt);
    int n;
    int len;
    int sum;
    n = s_data.size();
    nxt = i;
    if (nxt >= n) return 3;
    if (s_err[nxt]) begin nxt++; return 0; end
    len = s_data[nxt];
    nxt++;
    if (len == 0 || len > MAX_LEN) return 1;
    sum = len;
    for (int k = 0; k <= len; k++) begin
      if (nxt >= n) return 3;
      if (s_err[nxt]) begin nxt++; return 0; end
      sum += s_data[nxt];
      nxt++;
    end
    return (sum % 256 == 0) ? -1 : 2;
  endfunction

  task automatic build_expect();
    int i;
    int nx;
    int r;
    int len;
    i = 0;
    while (i < s_data.size()) begin
      if (s_data[i] != SOF) begin
        i++;
      end else begin
        r = parse_frame(i + 1, nx);
        if (r < 0) begin
          len = s_data[i + 1];
          for (int k = 0; k < len; k++) begin
            exp_bytes.push_back(s_data[i + 2 + k]);
            exp_last.push_back(k == len - 1);
          end
          exp_ok++;
        end else begin
          exp_codes.push_back(r);
        end
        i = nx;
      end
    end
  endtask

  // Feed the stream, observe outputs mid-cycle, stop once drained and quiet.
  task automatic run(input int max_cycles);
    int idle;
    int cyc;
    bit hold_chk;
    logic [7:0] hold_d;
    logic hold_l;
    bit stall;
    idle = 0; cyc = 0; hold_chk = 1'b0; hold_d = 8'h00; hold_l = 1'b0;
    while (cyc < max_cycles && idle < 70) begin
      @(negedge clk);
      stall = rand_stall && ($urandom_range(0, 3) == 0);
      if (ptr < s_data.size() && !stall) begin
        u_if.i_rx_empty = 1'b0;
        u_if.i_rx_data  = s_data[ptr];
        u_if.i_err      = s_err[ptr] ? 3'($urandom_range(1, 7)) : 3'b000;
      end else begin
        u_if.i_rx_empty = 1'b1;
        u_if.i_rx_data  = 8'($urandom);
        u_if.i_err      = 3'($urandom);
      end
      case (ready_mode)
        0:       u_if.i_ready = 1'($urandom);
        1:       u_if.i_ready = cyc[0];
        default: u_if.i_ready = 1'b1;
      endcase
      #1;
      if (u_if.o_frame_ok) begin
        obs_ok++;
        check("ok_with_first_valid", u_if.o_valid, 1);
      end
      if (u_if.o_frame_err) begin
        obs_codes.push_back(u_if.o_err_code);
        err_cyc = cyc;
      end
      if (u_if.o_valid) begin
        check("no_pop_in_send", u_if.o_rd_uart, 0);
        if (hold_chk) begin
          check("hold_data", u_if.o_data, hold_d);
          check("hold_last", u_if.o_last, hold_l);
        end
        if (u_if.i_ready) begin
          obs_bytes.push_back(u_if.o_data);
          obs_last.push_back(u_if.o_last);
        end
        hold_chk = !u_if.i_ready;
        hold_d   = u_if.o_data;
        hold_l   = u_if.o_last;
      end else begin
        hold_chk = 1'b0;
      end
      if (u_if.o_rd_uart) begin
        ptr++; pops++; last_pop_cyc = cyc;
      end
      if (ptr >= s_data.size() && !u_if.o_valid) idle++;
      else idle = 0;
      cyc++;
    end
    check("drain_within_budget", idle >= 70, 1);
  endtask

  task automatic compare(input string tag);
    check({tag, ":bytes"}, obs_bytes.size(), exp_bytes.size());
    for (int k = 0; k < exp_bytes.size() && k < obs_bytes.size(); k++) begin
      check({tag, ":data"}, obs_bytes[k], exp_bytes[k]);
      check({tag, ":last"}, obs_last[k], exp_last[k]);
    end
    check({tag, ":frames_ok"}, obs_ok, exp_ok);
    check({tag, ":errors"}, obs_codes.size(), exp_codes.size());
    for (int k = 0; k < exp_codes.size() && k < obs_codes.size(); k++)
      check({tag, ":err_code"}, obs_codes[k], exp_codes[k]);
  endtask

  task automatic push_random_good(input int len);
    logic [7:0] pl[$];
    for (int k = 0; k < len; k++) pl.push_back(8'($urandom));
    push_frame(pl, 1'b0, -1);
  endtask

  task automatic gen_random(input int nframes);
    int g;
    int kind;
    int len;
    logic [7:0] b;
    logic [7:0] pl[$];
    for (int f = 0; f < nframes; f++) begin
      g = $urandom_range(0, 3);
      for (int k = 0; k < g; k++) begin
        b = 8'($urandom);
        if (b == SOF) b = 8'h00;
        push(b);
      end
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, MAX_LEN);
      pl.delete();
      for (int k = 0; k < len; k++) pl.push_back(8'($urandom));
      if (kind <= 6)      push_frame(pl, 1'b0, -1);
      else if (kind == 7) push_frame(pl, 1'b1, -1);
      else if (kind == 8) push_frame(pl, 1'b0, $urandom_range(0, len + 1));
      else begin
        push(SOF);
        push(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (u_if_nt.o_frame_err) nt_err++;
      if (u_if_nt.o_frame_ok)  nt_ok++;
    end
  end

  initial begin
    #700_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.i_rx_empty = 1'b0; u_if.i_rx_data = SOF; u_if.i_err = 3'b000; u_if.i_ready = 1'b1;
    u_if_nt.i_rx_empty = 1'b1; u_if_nt.i_rx_data = 8'h00; u_if_nt.i_err = 3'b000;
    u_if_nt.i_ready = 1'b1;
    rand_stall = 1'b0; ready_mode = 2;
    new_scenario();

    // Reset values, with a non-empty FIFO present.
    repeat (3) @(negedge clk);
    #1;
    check("rst_rd_uart", u_if.o_rd_uart, 0);
    check("rst_valid", u_if.o_valid, 0);
    check("rst_last", u_if.o_last, 0);
    check("rst_data", u_if.o_data, 0);
    check("rst_frame_ok", u_if.o_frame_ok, 0);
    check("rst_frame_err", u_if.o_frame_err, 0);
    check("rst_err_code", u_if.o_err_code, 0);
    u_if.i_rx_empty = 1'b1;
    @(negedge clk) rst_n = 1'b1;

    // Good frame.
    new_scenario();
    foreach (nt_bytes[k]) if (k < 0) push(8'h00);
    push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h97);
    build_expect();
    run(400);
    compare("good");
    check("good_pops", pops, 6);
    check("good_first_byte", (obs_bytes.size() > 0) ? obs_bytes[0] : 8'hXX, 8'h11);

    // Hunt plus bad checksum, then a good frame.
    new_scenario();
    push(8'h00); push(8'hFF); push(8'hA5); push(8'h02); push(8'h10); push(8'h20); push(8'h00);
    push_random_good(5);
    build_expect();
    run(400);
    compare("badchk");

    // Length bounds.
    new_scenario();
    push(SOF); push(8'h00); push(SOF); push(8'(MAX_LEN + 1));
    push_random_good(MAX_LEN);
    build_expect();
    run(400);
    compare("lenbounds");

    // Backpressure with i_ready toggling and the next frame already queued.
    new_scenario();
    ready_mode = 1;
    push_random_good(8);
    push_random_good(3);
    build_expect();
    run(600);
    compare("backpressure");
    ready_mode = 2;

    // Line error on a payload pop, then a good frame.
    new_scenario();
    push(8'hA5); push(8'h03); push(8'h11, 1'b1); push(8'h22); push(8'h33); push(8'h97);
    push_random_good(4);
    build_expect();
    run(400);
    compare("line_err");

    // Timeout after A5 04 11.
    new_scenario();
    push(8'hA5); push(8'h04); push(8'h11);
    build_expect();
    run(400);
    compare("timeout");
    check("timeout_latency", err_cyc - 1 - last_pop_cyc, TMO);

    // Reset mid-frame after A5 03 11.
    new_scenario();
    push(8'hA5); push(8'h03); push(8'h11);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      u_if.i_rx_empty = 1'b0; u_if.i_rx_data = s_data[k]; u_if.i_err = 3'b000;
    end
    @(negedge clk);
    u_if.i_rx_data = 8'h22;
    rst_n = 1'b0;
    #1;
    check("midrst_rd_uart", u_if.o_rd_uart, 0);
    check("midrst_valid", u_if.o_valid, 0);
    check("midrst_err_code", u_if.o_err_code, 0);
    check("midrst_frame_err", u_if.o_frame_err, 0);
    @(negedge clk);
    #1;
    check("midrst_frame_err2", u_if.o_frame_err, 0);
    u_if.i_rx_empty = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    new_scenario();
    push_random_good(6);
    build_expect();
    run(400);
    compare("after_reset");

    // Randomised streams with FIFO stalls and random sink backpressure.
    rand_stall = 1'b1; ready_mode = 0;
    for (int r = 0; r < 2; r++) begin
      new_scenario();
      gen_random(30);
      build_expect();
      run(20000);
      compare("random");
    end

    // Timeout disabled: a long stall mid-frame must not abort.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); u_if_nt.i_rx_empty = 1'b0; u_if_nt.i_rx_data = nt_bytes[k];
    end
    @(negedge clk); u_if_nt.i_rx_empty = 1'b1;
    repeat (200) @(negedge clk);
    for (int k = 3; k < 7; k++) begin
      @(negedge clk); u_if_nt.i_rx_empty = 1'b0; u_if_nt.i_rx_data = nt_bytes[k];
    end
    @(negedge clk); u_if_nt.i_rx_empty = 1'b1;
    repeat (20) @(negedge clk);
    check("notimeout_no_err", nt_err, 0);
    check("notimeout_frame_ok", nt_ok, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Downstream consumer of the UART's receive FIFO. Pops received bytes, hunts for a start-of-frame byte, and parses a length-prefixed, checksummed frame into an internal payload buffer. Releases the payload on a valid/ready byte stream only after the checksum verifies. Malformed, corrupted or stalled frames are reported and discarded.

## Interface
- MAX_LEN, 16, maximum payload bytes per frame and buffer depth (≥1)
- SOF, 8'hA5, start-of-frame byte value
- TIMEOUT_CYCLES, 1_000_000, consecutive idle cycles mid-frame before abort; 0 disables the timeout
- i_clk  in  1  clock
- i_rst_n  in  1  reset; one clock, asynchronous, active-low
- i_rx_empty  in  1  UART RX FIFO empty
- i_rx_data  in  8  RX FIFO head byte, valid while i_rx_empty=0
- i_err  in  3  UART receive error flags; nonzero means a line error
- o_rd_uart  out  1  RX FIFO pop strobe; the byte on i_rx_data is consumed in the same cycle
- o_data  out  8  payload byte
- o_valid  out  1  o_data valid
- i_ready  in  1  sink accepts byte when o_valid&i_ready
- o_last  out  1  marks final payload byte (qualified by o_valid)
- o_frame_ok  out  1  one-cycle pulse: checksum good, payload release starts
- o_frame_err  out  1  one-cycle pulse: frame aborted
- o_err_code  out  2  valid with o_frame_err: 00 line error, 01 bad length, 10 checksum, 11 timeout

## Operation
- Frame on the wire: SOF, LEN (1..MAX_LEN), LEN payload bytes, CHK.
- Acceptance rule: (LEN + payload + CHK) mod 256 == 0, using an 8-bit wrapping accumulator.
- Pop rule: o_rd_uart = ~i_rx_empty in HUNT/LEN/PAYLOAD/CHK. It is 0 in SEND, which backpressures the FIFO, and forced 0 while i_rst_n is low.
- HUNT: popped bytes ≠ SOF are discarded silently; i_err is ignored. On SOF: go to LEN and clear the accumulator.
- LEN: on pop, if the byte is 0 or > MAX_LEN, abort with code 01. Otherwise store the length, load the accumulator with the byte, and go to PAYLOAD.
- PAYLOAD: on each pop, write the byte to buf[wr_idx], add it to the accumulator, and increment wr_idx. After the LEN-th byte, go to CHK. A SOF value inside the payload is ordinary data.
- CHK: on pop, if accumulator + byte ≠ 0 mod 256, abort with code 10. Otherwise pulse o_frame_ok and go to SEND.
- Line error: i_err ≠ 0 in any cycle with o_rd_uart=1 in LEN/PAYLOAD/CHK aborts with code 00. This takes priority over the length and checksum checks for that byte.
- Timeout: an idle counter runs in LEN/PAYLOAD/CHK and increments each cycle without a pop. It clears on a pop and on state entry. When it reaches TIMEOUT_CYCLES, abort with code 11.
- Abort: pulse o_frame_err with o_err_code and return to HUNT. The buffer contents are not emitted. Subsequent bytes are hunted normally, with no resynchronisation inside the aborted frame.
- SEND: o_valid=1, o_data=buf[rd_idx], o_last=(rd_idx==len-1).
  - On o_valid&i_ready, rd_idx increments.
  - The handshake on the last byte returns the block to HUNT, with o_valid=0 the next cycle.
- Widths: idx/len registers are $clog2(MAX_LEN+1) bits; the idle counter is $clog2(TIMEOUT_CYCLES+1) bits.

## Timing
- Reset values: o_valid=0, o_last=0, o_data=0, o_frame_ok=0, o_frame_err=0, o_err_code=0, state=HUNT, all counters 0. o_rd_uart=0 during reset.
- Pop throughput: one byte per cycle in parse states. A stalled FIFO (i_rx_empty=1) simply holds state.
- o_frame_ok and the first o_valid are asserted together, in the cycle after the CHK pop.
- o_frame_err and o_err_code are registered and appear the cycle after the offending pop or the timeout terminal cycle. o_err_code holds until the next error.
- SEND output: o_data/o_last are stable while o_valid=1 and i_ready=0. Sustained i_ready=1 drains LEN bytes in LEN cycles.
- Reset mid-frame or mid-SEND: immediate return to reset values. Partial payload is lost with no error pulse.

## Test plan
- Good frame: FIFO holds A5 03 11 22 33 97 → o_frame_ok one pulse; o_data 11,22,33 on three handshakes, o_last with 33; six pops; o_frame_err stays 0.
- Hunt plus bad checksum: bytes 00 FF A5 02 10 20 00 → first two discarded silently; o_frame_err with code 10; no o_valid. A following good frame parses correctly.
- Length bounds: A5 00 and A5 11 (MAX_LEN=16) → code 01 each. A5 10 + 16 bytes + correct CHK → accepted, 16 bytes out.
- Backpressure: good frame with i_ready toggling 0/1 every cycle → o_data held while i_ready=0; no pops during SEND even if the FIFO refills.
- Line error and timeout (TIMEOUT_CYCLES=50):
  - i_err=3'b010 on the payload pop → code 00.
  - A5 04 11, then FIFO empty for 50 cycles → code 11 exactly 50 cycles after the last pop.
  - With TIMEOUT_CYCLES=0, no abort ever occurs.
- Reset mid-frame: assert i_rst_n low after A5 03 11 → all outputs reach reset values; no o_frame_err; next complete frame parses correctly.
